// File: rtl/udp_reg_multi_inst_iface.sv
// Register ring stage for a block holding NUM_INSTANCES identical register sets.
// Define REG_IFACE_TIMEOUT_EN to add a backend wait limit of TIMEOUT_CYCLES.
module udp_reg_multi_inst_iface #(
    parameter int REG_ADDR_WIDTH      = 23,
    parameter int DATA_WIDTH          = 32,
    parameter int SRC_WIDTH           = 2,
    parameter int BLOCK_ADDR_WIDTH    = 16,
    parameter int INST_REG_ADDR_WIDTH = 6,
    parameter logic [REG_ADDR_WIDTH-BLOCK_ADDR_WIDTH-1:0] BLOCK_TAG = 7'h01,
    parameter int NUM_INSTANCES       = 8,
    parameter int NUM_REGS_USED       = 17,
    parameter logic [NUM_REGS_USED-1:0] RO_MASK = '0,
    parameter int TIMEOUT_CYCLES      = 1023,
    localparam int INST_WIDTH = (NUM_INSTANCES > 1) ? $clog2(NUM_INSTANCES) : 1,
    localparam int REG_WIDTH  = (NUM_REGS_USED > 1) ? $clog2(NUM_REGS_USED) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      reg_req_in,
    input  logic                      reg_ack_in,
    input  logic                      reg_rd_wr_L_in,
    input  logic [REG_ADDR_WIDTH-1:0] reg_addr_in,
    input  logic [DATA_WIDTH-1:0]     reg_data_in,
    input  logic [SRC_WIDTH-1:0]      reg_src_in,
    output logic                      reg_req_out,
    output logic                      reg_ack_out,
    output logic                      reg_rd_wr_L_out,
    output logic [REG_ADDR_WIDTH-1:0] reg_addr_out,
    output logic [DATA_WIDTH-1:0]     reg_data_out,
    output logic [SRC_WIDTH-1:0]      reg_src_out,
    output logic                      be_req,
    output logic                      be_rd_wr_L,
    output logic [REG_WIDTH-1:0]      be_reg,
    output logic [INST_WIDTH-1:0]     be_inst,
    output logic [DATA_WIDTH-1:0]     be_wr_data,
    input  logic                      be_done,
    input  logic [DATA_WIDTH-1:0]     be_rd_data,
    output logic                      overrun_err,
    output logic                      timeout_err
);

    localparam int PAD_WIDTH = BLOCK_ADDR_WIDTH - INST_REG_ADDR_WIDTH - INST_WIDTH;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t state, state_next;

    logic [REG_ADDR_WIDTH-BLOCK_ADDR_WIDTH-1:0] tag_field;
    logic [INST_REG_ADDR_WIDTH-1:0]             reg_field;
    logic [INST_WIDTH-1:0]                      inst_field;
    logic [PAD_WIDTH-1:0]                       pad_field;
    logic tag_hit, addr_good, ro_bit, ro_hit;

    logic                      cap_rd_wr_L;
    logic [REG_ADDR_WIDTH-1:0] cap_addr;
    logic [DATA_WIDTH-1:0]     cap_data;
    logic [SRC_WIDTH-1:0]      cap_src;
    logic [DATA_WIDTH-1:0]     resp_data;
    logic                      capture;
    logic                      tmo_hit;

    logic                      req_nxt, ack_nxt, rd_wr_L_nxt;
    logic [REG_ADDR_WIDTH-1:0] addr_nxt;
    logic [DATA_WIDTH-1:0]     data_nxt;
    logic [SRC_WIDTH-1:0]      src_nxt;

    assign tag_field  = reg_addr_in[REG_ADDR_WIDTH-1:BLOCK_ADDR_WIDTH];
    assign reg_field  = reg_addr_in[INST_REG_ADDR_WIDTH-1:0];
    assign inst_field = reg_addr_in[INST_REG_ADDR_WIDTH +: INST_WIDTH];
    assign pad_field  = reg_addr_in[BLOCK_ADDR_WIDTH-1:INST_REG_ADDR_WIDTH+INST_WIDTH];

    assign tag_hit   = (tag_field == BLOCK_TAG);
    assign addr_good = ({1'b0, reg_field} < (INST_REG_ADDR_WIDTH+1)'(NUM_REGS_USED)) &&
                       ({1'b0, inst_field} < (INST_WIDTH+1)'(NUM_INSTANCES)) &&
                       (pad_field == '0);

    // Only mapped indices can select a mask bit; anything else reads as writable.
    always_comb begin
        ro_bit = 1'b0;
        for (int i = 0; i < NUM_REGS_USED; i++) begin
            if (reg_field == INST_REG_ADDR_WIDTH'(i)) ro_bit = RO_MASK[i];
        end
    end

    assign ro_hit = !reg_rd_wr_L_in && ro_bit;

    assign be_rd_wr_L = cap_rd_wr_L;
    assign be_reg     = cap_addr[REG_WIDTH-1:0];
    assign be_inst    = cap_addr[INST_REG_ADDR_WIDTH +: INST_WIDTH];
    assign be_wr_data = cap_data;

    always_comb begin
        state_next  = state;
        capture     = 1'b0;
        req_nxt     = 1'b0;
        ack_nxt     = 1'b0;
        rd_wr_L_nxt = 1'b0;
        addr_nxt    = '0;
        data_nxt    = '0;
        src_nxt     = '0;
        case (state)
            IDLE: begin
                if (reg_req_in && tag_hit && addr_good && !ro_hit) begin
                    capture    = 1'b1;
                    state_next = BUSY;
                end else begin
                    req_nxt     = reg_req_in;
                    ack_nxt     = reg_ack_in;
                    rd_wr_L_nxt = reg_rd_wr_L_in;
                    addr_nxt    = reg_addr_in;
                    data_nxt    = reg_data_in;
                    src_nxt     = reg_src_in;
                    if (reg_req_in && tag_hit) begin
                        ack_nxt = 1'b1;
                        if (!addr_good) data_nxt = DATA_WIDTH'(32'hDEAD_BEEF);
                    end
                end
            end
            BUSY: begin
                if (be_done || tmo_hit) state_next = RESP;
            end
            RESP: begin
                req_nxt     = 1'b1;
                ack_nxt     = 1'b1;
                rd_wr_L_nxt = cap_rd_wr_L;
                addr_nxt    = cap_addr;
                data_nxt    = resp_data;
                src_nxt     = cap_src;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // be_done outranks a coinciding timeout when choosing the response data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            reg_req_out     <= 1'b0;
            reg_ack_out     <= 1'b0;
            reg_rd_wr_L_out <= 1'b0;
            reg_addr_out    <= '0;
            reg_data_out    <= '0;
            reg_src_out     <= '0;
            be_req          <= 1'b0;
            cap_rd_wr_L     <= 1'b0;
            cap_addr        <= '0;
            cap_data        <= '0;
            cap_src         <= '0;
            resp_data       <= '0;
            overrun_err     <= 1'b0;
        end else begin
            state           <= state_next;
            reg_req_out     <= req_nxt;
            reg_ack_out     <= ack_nxt;
            reg_rd_wr_L_out <= rd_wr_L_nxt;
            reg_addr_out    <= addr_nxt;
            reg_data_out    <= data_nxt;
            reg_src_out     <= src_nxt;
            be_req          <= (state_next == BUSY);
            if (capture) begin
                cap_rd_wr_L <= reg_rd_wr_L_in;
                cap_addr    <= reg_addr_in;
                cap_data    <= reg_data_in;
                cap_src     <= reg_src_in;
            end
            if (state == BUSY) begin
                if (be_done) resp_data <= cap_rd_wr_L ? be_rd_data : cap_data;
                else if (tmo_hit) resp_data <= DATA_WIDTH'(32'hDEAD_0002);
            end
            if (reg_req_in && state != IDLE) overrun_err <= 1'b1;
        end
    end

`ifdef REG_IFACE_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    // Count sits at zero outside BUSY, so each access starts from a fresh count.
    assign tmo_hit = (state == BUSY) && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            tmo_cnt <= (state == BUSY) ? tmo_cnt + 16'd1 : 16'd0;
            if (tmo_hit && !be_done) timeout_err <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    // A cycle count is never negative, so the flag is constant zero in this build.
    assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_udp_reg_multi_inst_iface.sv
// Self-checking bench for udp_reg_multi_inst_iface: directed and randomized ring
// requests checked against a spec-level model of decode, latency and flags.
module tb_udp_reg_multi_inst_iface;

    localparam int RO_REG     = 2;
    localparam int TB_TIMEOUT = 8;

    typedef struct packed {
        logic        req;
        logic        ack;
        logic        rd_wr_L;
        logic [22:0] addr;
        logic [31:0] data;
        logic [1:0]  src;
    } ring_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_req_in, reg_ack_in, reg_rd_wr_L_in;
    logic [22:0] reg_addr_in;
    logic [31:0] reg_data_in;
    logic [1:0]  reg_src_in;
    logic        reg_req_out, reg_ack_out, reg_rd_wr_L_out;
    logic [22:0] reg_addr_out;
    logic [31:0] reg_data_out;
    logic [1:0]  reg_src_out;
    logic        be_req, be_rd_wr_L;
    logic [4:0]  be_reg;
    logic [2:0]  be_inst;
    logic [31:0] be_wr_data;
    logic        be_done;
    logic [31:0] be_rd_data;
    logic        overrun_err, timeout_err;

    int checks = 0;
    int failures = 0;
    bit model_overrun = 1'b0;

    udp_reg_multi_inst_iface #(
        .RO_MASK        (17'(1 << RO_REG)),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .reg_req_in      (reg_req_in),
        .reg_ack_in      (reg_ack_in),
        .reg_rd_wr_L_in  (reg_rd_wr_L_in),
        .reg_addr_in     (reg_addr_in),
        .reg_data_in     (reg_data_in),
        .reg_src_in      (reg_src_in),
        .reg_req_out     (reg_req_out),
        .reg_ack_out     (reg_ack_out),
        .reg_rd_wr_L_out (reg_rd_wr_L_out),
        .reg_addr_out    (reg_addr_out),
        .reg_data_out    (reg_data_out),
        .reg_src_out     (reg_src_out),
        .be_req          (be_req),
        .be_rd_wr_L      (be_rd_wr_L),
        .be_reg          (be_reg),
        .be_inst         (be_inst),
        .be_wr_data      (be_wr_data),
        .be_done         (be_done),
        .be_rd_data      (be_rd_data),
        .overrun_err     (overrun_err),
        .timeout_err     (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, want);
        end
    endtask

    function automatic ring_t ring_obs();
        return {reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out};
    endfunction

    task automatic apply_stimulus(input logic req, input logic ack, input logic rdwr,
                                  input logic [22:0] addr, input logic [31:0] data, input logic [1:0] src);
        reg_req_in     = req;
        reg_ack_in     = ack;
        reg_rd_wr_L_in = rdwr;
        reg_addr_in    = addr;
        reg_data_in    = data;
        reg_src_in     = src;
    endtask

    // Idle-state behaviour from the address rules: either a backend access, or an
    // expected ring word one cycle later.
    function automatic void model_idle(input logic req, input logic ack, input logic rdwr,
                                       input logic [22:0] addr, input logic [31:0] data,
                                       input logic [1:0] src, output bit access, output ring_t want);
        int tag   = int'(addr) / 65536;
        int low   = int'(addr) % 65536;
        int reg_i = low % 64;
        int inst  = (low / 64) % 8;
        int pad   = low / 512;
        bit mapped = (reg_i < 17) && (inst < 8) && (pad == 0);
        bit ro     = mapped && !rdwr && (reg_i == RO_REG);
        want.req     = req;
        want.ack     = ack;
        want.rd_wr_L = rdwr;
        want.addr    = addr;
        want.data    = data;
        want.src     = src;
        access = 1'b0;
        if (req && tag == 1) begin
            if (mapped && !ro) access = 1'b1;
            else begin
                want.ack = 1'b1;
                if (!mapped) want.data = 32'hDEAD_BEEF;
            end
        end
    endfunction

    // Backend access: be_done in cycle lat after the request, response at lat+2.
    task automatic run_access(input logic rdwr, input logic [22:0] addr, input logic [31:0] data,
                              input logic [1:0] src, input int lat, input logic [31:0] rd, input int intrude);
        ring_t want;
        int reg_i = int'(addr) % 64;
        int inst  = (int'(addr) / 64) % 8;
        want.req     = 1'b1;
        want.ack     = 1'b1;
        want.rd_wr_L = rdwr;
        want.addr    = addr;
        want.data    = rdwr ? rd : data;
        want.src     = src;
        apply_stimulus(1'b1, 1'b0, rdwr, addr, data, src);
        tick();
        for (int c = 1; c <= lat + 1; c++) begin
            check_vec("ring_quiet", 64'(ring_obs()), 64'd0);
            check_bit("be_req", be_req, c <= lat);
            if (c <= lat) begin
                check_vec("be_reg", 64'(be_reg), 64'(reg_i));
                check_vec("be_inst", 64'(be_inst), 64'(inst));
                check_bit("be_rd_wr_L", be_rd_wr_L, rdwr);
                if (!rdwr) check_vec("be_wr_data", 64'(be_wr_data), 64'(data));
            end
            check_bit("overrun_err", overrun_err, model_overrun);
            if (c == intrude) apply_stimulus(1'b1, 1'b0, 1'b1, addr, 32'($urandom), 2'($urandom));
            else apply_stimulus(1'b0, 1'b0, 1'b0, 23'd0, 32'd0, 2'd0);
            be_done    = (c == lat);
            be_rd_data = (c == lat) ? rd : 32'($urandom);
            tick();
            if (c == intrude) model_overrun = 1'b1;
        end
        be_done = 1'b0;
        check_vec("response", 64'(ring_obs()), 64'(want));
        check_bit("be_req_after", be_req, 1'b0);
    endtask

    task automatic run_request(input logic req, input logic ack, input logic rdwr,
                               input logic [22:0] addr, input logic [31:0] data, input logic [1:0] src);
        ring_t want;
        bit access;
        model_idle(req, ack, rdwr, addr, data, src, access, want);
        if (access) begin
            run_access(rdwr, addr, data, src, $urandom_range(1, 5), 32'($urandom), 0);
        end else begin
            apply_stimulus(req, ack, rdwr, addr, data, src);
            be_done    = 1'($urandom_range(0, 1));
            be_rd_data = 32'($urandom);
            tick();
            apply_stimulus(1'b0, 1'b0, 1'b0, 23'd0, 32'd0, 2'd0);
            be_done = 1'b0;
            check_vec("immediate", 64'(ring_obs()), 64'(want));
            check_bit("be_req_quiet", be_req, 1'b0);
        end
    endtask

    initial begin
        logic [6:0]  tag;
        logic [22:0] addr;
        reset      = 1'b1;
        be_done    = 1'b0;
        be_rd_data = 32'd0;
        apply_stimulus(1'b0, 1'b0, 1'b0, 23'd0, 32'd0, 2'd0);
        tick();
        tick();
        check_vec("reset_ring", 64'(ring_obs()), 64'd0);
        check_bit("reset_be_req", be_req, 1'b0);
        check_bit("reset_overrun", overrun_err, 1'b0);
        check_bit("reset_timeout", timeout_err, 1'b0);
        reset = 1'b0;

        $display("[TB] pass-through, read hit, unmapped and read-only cases");
        run_request(1'b1, 1'b0, 1'b1, {7'h02, 16'h0145}, 32'h1234_5678, 2'd3);
        run_access(1'b1, {7'h01, 7'd0, 3'd3, 6'd5}, 32'd0, 2'd1, 4, 32'hCAFE_0005, 0);
        run_request(1'b1, 1'b0, 1'b1, {7'h01, 7'd0, 3'd0, 6'd17}, 32'h0BAD_F00D, 2'd0);
        run_request(1'b1, 1'b0, 1'b1, {7'h01, 7'd1, 3'd0, 6'd1}, 32'h0000_0001, 2'd1);
        run_request(1'b1, 1'b0, 1'b0, {7'h01, 7'd0, 3'd4, 6'd2}, 32'h5555_AAAA, 2'd2);
        run_access(1'b0, {7'h01, 7'd0, 3'd7, 6'd16}, 32'hA5A5_0F0F, 2'd2, 1, 32'hFFFF_FFFF, 0);

        $display("[TB] randomized requests");
        for (int n = 0; n < 24; n++) begin
            tag  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'h01;
            addr = {tag,
                    ($urandom_range(0, 7) == 0) ? 7'($urandom_range(1, 127)) : 7'd0,
                    3'($urandom_range(0, 7)),
                    6'($urandom_range(0, 20))};
            run_request(1'($urandom_range(0, 4) != 0), 1'($urandom), 1'($urandom),
                        addr, 32'($urandom), 2'($urandom));
        end

        $display("[TB] overrun during busy");
        check_bit("overrun_before", overrun_err, 1'b0);
        run_access(1'b1, {7'h01, 7'd0, 3'd2, 6'd9}, 32'd0, 2'd0, 4, 32'h1357_9BDF, 2);
        run_access(1'b0, {7'h01, 7'd0, 3'd5, 6'd3}, 32'h2468_ACE0, 2'd1, 3, 32'd0, 4);
        tick();
        tick();
        check_bit("overrun_sticky", overrun_err, 1'b1);

        $display("[TB] reset during busy");
        apply_stimulus(1'b1, 1'b0, 1'b1, {7'h01, 7'd0, 3'd1, 6'd4}, 32'd0, 2'd1);
        tick();
        apply_stimulus(1'b0, 1'b0, 1'b0, 23'd0, 32'd0, 2'd0);
        check_bit("busy_before_reset", be_req, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_overrun = 1'b0;
        check_bit("abort_be_req", be_req, 1'b0);
        check_vec("abort_ring", 64'(ring_obs()), 64'd0);
        check_bit("abort_overrun", overrun_err, 1'b0);
        be_done    = 1'b1;
        be_rd_data = 32'h7777_7777;
        tick();
        be_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check_vec("no_response", 64'(ring_obs()), 64'd0);
            check_bit("no_be_req", be_req, 1'b0);
            tick();
        end
        run_request(1'b1, 1'b1, 1'b0, {7'h40, 16'hBEEF}, 32'h0102_0304, 2'd2);

`ifdef REG_IFACE_TIMEOUT_EN
        $display("[TB] backend timeout");
        begin
            ring_t want;
            want.req     = 1'b1;
            want.ack     = 1'b1;
            want.rd_wr_L = 1'b1;
            want.addr    = {7'h01, 7'd0, 3'd6, 6'd11};
            want.data    = 32'hDEAD_0002;
            want.src     = 2'd3;
            apply_stimulus(1'b1, 1'b0, 1'b1, want.addr, 32'd0, 2'd3);
            tick();
            apply_stimulus(1'b0, 1'b0, 1'b0, 23'd0, 32'd0, 2'd0);
            for (int c = 1; c <= TB_TIMEOUT + 1; c++) begin
                check_bit("tmo_be_req", be_req, c <= TB_TIMEOUT);
                check_bit("tmo_flag", timeout_err, c > TB_TIMEOUT);
                tick();
            end
            check_vec("tmo_response", 64'(ring_obs()), 64'(want));
            check_bit("tmo_sticky", timeout_err, 1'b1);
        end
`else
        check_bit("timeout_tied", timeout_err, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/udp_reg_multi_inst_iface.md
Name: udp_reg_multi_inst_iface

Overview:
- Parametrised host-side register ring stage for blocks that hold NUM_INSTANCES identical register sets, e.g. per-queue or per-port, in the udp_reg_grp chain.
- Decodes tag, instance and register fields; captures a hitting request; issues one backend access; holds the ring until the backend answers.
- Adds three features: backend timeout, read-only write filtering, and a sticky overrun flag.

Parameters:
- REG_ADDR_WIDTH, 23, ring address width.
- DATA_WIDTH, 32, ring data width.
- SRC_WIDTH, 2, ring source-id width.
- BLOCK_ADDR_WIDTH, 16, low address bits owned by the block (instance + register fields).
- INST_REG_ADDR_WIDTH, 6, register-index field width inside an instance.
- BLOCK_TAG, 7'h01, value of address bits [REG_ADDR_WIDTH-1:BLOCK_ADDR_WIDTH] that selects this block.
- NUM_INSTANCES, 8, number of register sets.
- NUM_REGS_USED, 17, valid registers per instance, indices 0..NUM_REGS_USED-1.
- RO_MASK, 0, NUM_REGS_USED-bit mask; bit i=1 marks register i read-only.
- TIMEOUT_CYCLES, 1023, backend wait limit; only used with REG_IFACE_TIMEOUT_EN.
- Derived localparams: INST_WIDTH=max(1,clog2(NUM_INSTANCES)); REG_WIDTH=max(1,clog2(NUM_REGS_USED)).

Ports:
- clk, in, 1, clock.
- reset, in, 1, reset.
- reg_req_in / reg_ack_in / reg_rd_wr_L_in, in, 1 each, ring inputs.
- reg_addr_in, in, REG_ADDR_WIDTH, ring address.
- reg_data_in, in, DATA_WIDTH, ring data.
- reg_src_in, in, SRC_WIDTH, ring source id.
- reg_req_out / reg_ack_out / reg_rd_wr_L_out, out, 1 each, registered ring outputs.
- reg_addr_out, out, REG_ADDR_WIDTH, registered ring address.
- reg_data_out, out, DATA_WIDTH, registered ring data.
- reg_src_out, out, SRC_WIDTH, registered ring source id.
- be_req, out, 1, backend access request, level.
- be_rd_wr_L, out, 1, 1=read, 0=write.
- be_reg, out, REG_WIDTH, register index.
- be_inst, out, INST_WIDTH, instance index.
- be_wr_data, out, DATA_WIDTH, write data.
- be_done, in, 1, one-cycle completion strobe.
- be_rd_data, in, DATA_WIDTH, read result, valid with be_done.
- overrun_err, out, 1, sticky: ring request arrived while busy.
- timeout_err, out, 1, sticky: backend timed out; tied 0 without the feature.

Behaviour:
- Reset is synchronous, active-high on clock clk. Every output and internal register resets to 0; FSM resets to IDLE.
- Decode, combinational on inputs:
  - tag_hit = (tag field == BLOCK_TAG).
  - addr_good = (reg field < NUM_REGS_USED) && (inst field < NUM_INSTANCES). Bits between INST_WIDTH and the block field must be 0.
  - ro_hit = write && RO_MASK[reg].
- FSM states: IDLE, BUSY, RESP.
- IDLE (pass-through / immediate responses):
  - reg_req_in && tag_hit && addr_good && !ro_hit: capture req, rd_wr_L, addr, data and src; next cycle be_req=1 and state BUSY. Ring outputs go to 0 for that cycle.
  - reg_req_in && tag_hit && (!addr_good || ro_hit): forward with reg_ack_out=1.
    - Unmapped address: reg_data_out=32'hDEAD_BEEF.
    - Read-only write: reg_data_out=reg_data_in; no backend access.
  - Otherwise: forward all inputs unchanged, 1-cycle latency; reg_ack_out=reg_ack_in.
- BUSY:
  - be_req and all be_* outputs held stable until be_done.
  - On be_done: be_req drops the same clock edge; go to RESP.
  - Ring outputs are 0. A reg_req_in seen here sets overrun_err and is dropped.
- RESP: one cycle, then IDLE.
  - Drive captured req/rd_wr_L/addr/src with reg_ack_out=1.
  - reg_data_out = be_rd_data latched at be_done for a read; the captured write data for a write.
- Request/done overlap: a be_done in IDLE or RESP is ignored. A ring request in RESP sets overrun_err.
- Back-to-back hits: the earliest second capture is the cycle after RESP. End-to-end latency = be_done latency + 2 cycles.
- Reset mid-BUSY: abort, be_req=0, no ring response emitted.

Optional Feature:
- Macro: REG_IFACE_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - At count==TIMEOUT_CYCLES without be_done: drop be_req, set timeout_err, go to RESP with reg_data_out=32'hDEAD_0002 and ack=1.
  - If be_done coincides with the timeout cycle, be_done wins.
- Undefined: no counter; BUSY waits indefinitely; timeout_err tied 0.

Test Plan:
- Pass-through: request with tag 7'h02 and data 32'h1234_5678 -> identical outputs 1 cycle later; ack unchanged; be_req stays 0.
- Read hit: tag match, inst 3, reg 5, read; be_done after 4 cycles with be_rd_data=32'hCAFE_0005 -> be_inst=3, be_reg=5; ring response ack=1, data 32'hCAFE_0005, 6 cycles after request.
- Unmapped/RO: reg 17 read -> ack=1 with 32'hDEAD_BEEF. Write to reg 2 with RO_MASK bit2=1 -> ack=1, data unchanged, be_req never asserted.
- Overrun and reset: second reg_req_in during BUSY -> overrun_err=1 and stays 1. Reset asserted in BUSY -> be_req=0 and all outputs 0 next cycle; no response.
- Timeout (macro defined, TIMEOUT_CYCLES=8): be_done never asserted -> be_req drops after 8 BUSY cycles; response data 32'hDEAD_0002; timeout_err=1.
